// File: rtl/cnn_layer_accel_octo_loader.sv
// Host-side loader for the octo datain port: new_map pulse, generated sequence table, then the pixel map.
// Define OCTO_LOADER_SEQ_GEN_EN to build in the on-chip sequence generator.
module cnn_layer_accel_octo_loader #(
    parameter int C_PIXEL_WIDTH    = 16,
    parameter int C_SEQ_DATA_WIDTH = 14,
    parameter int C_MAX_DIM        = 512,
    parameter int C_ADDR_WIDTH     = $clog2(C_MAX_DIM * C_MAX_DIM),
    localparam int DIM_W = $clog2(C_MAX_DIM),
    localparam int DW    = (C_PIXEL_WIDTH > C_SEQ_DATA_WIDTH) ? C_PIXEL_WIDTH : C_SEQ_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_W-1:0]         num_rows,
    input  logic [DIM_W-1:0]         num_cols,
    output logic                     new_map,
    output logic [DW-1:0]            datain,
    output logic                     datain_valid,
    output logic                     seq_datain_tag,
    input  logic                     seq_datain_rdy,
    output logic                     pixel_datain_tag,
    input  logic                     pixel_datain_rdy,
    output logic                     pix_rd_en,
    output logic [C_ADDR_WIDTH-1:0]  pix_rd_addr,
    input  logic [C_PIXEL_WIDTH-1:0] pix_rd_data,
    output logic                     busy,
    output logic                     done
);
    localparam int CW = C_ADDR_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_NEWMAP, S_SEQ, S_GAP, S_PIX, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            rd_left_q, rd_left_d, out_left_q, out_left_d;
    logic [C_ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                     rd_pend_q, rd_pend_d;
    logic [C_PIXEL_WIDTH-1:0] buf_q [2];
    logic [C_PIXEL_WIDTH-1:0] buf_d [2];
    logic                     buf_head_q, buf_head_d;
    logic [1:0]               buf_cnt_q, buf_cnt_d;

    logic [CW-1:0]               rows_p1, cols_p1, map_size;
    logic                        pix_valid, pix_xfer, slot_free, push, pop;
    logic [C_PIXEL_WIDTH-1:0]    pix_word;
    logic                        seq_valid, seq_last_xfer;
    logic [C_SEQ_DATA_WIDTH-1:0] seq_word;

`ifdef OCTO_LOADER_SEQ_GEN_EN
    logic [DIM_W-1:0] cols_q, cols_d, col_q, col_d;
    logic [2:0]       widx_q, widx_d;
    logic [9:0]       sv_q [5];
    logic [9:0]       sv_d [5];
    logic [9:0]       cur_sv;
    logic             seq_xfer, col_nz, w_s, w_rm, w_rst, w_p;

    // sv_q holds the current column's SEQ field for each of the five word slots.
    always_comb begin
        cols_d        = cols_q;
        col_d         = col_q;
        widx_d        = widx_q;
        sv_d          = sv_q;
        seq_last_xfer = 1'b0;
        seq_valid     = (state_q == S_SEQ);
        seq_xfer      = seq_valid && seq_datain_rdy;
        case (widx_q)
            3'd0:    cur_sv = sv_q[0];
            3'd1:    cur_sv = sv_q[1];
            3'd2:    cur_sv = sv_q[2];
            3'd3:    cur_sv = sv_q[3];
            default: cur_sv = sv_q[4];
        endcase
        col_nz   = (col_q != '0);
        w_s      = ((widx_q == 3'd0) && col_nz) || ((widx_q == 3'd2) && !col_nz);
        w_rm     = (widx_q == 3'd4);
        w_rst    = (widx_q == 3'd0);
        w_p      = ((widx_q == 3'd0) && !col_q[0]) || ((widx_q == 3'd1) && col_q[0]);
        seq_word = C_SEQ_DATA_WIDTH'({w_s, w_rm, w_rst, w_p, cur_sv});
        if (state_q == S_IDLE && start)
            cols_d = num_cols;
        if (state_q == S_NEWMAP) begin
            col_d  = '0;
            widx_d = 3'd0;
            sv_d   = '{10'd0, 10'd2, 10'd512, 10'd513, 10'd514};
        end else if (seq_xfer) begin
            if (widx_q != 3'd4) begin
                widx_d = widx_q + 3'd1;
            end else begin
                widx_d = 3'd0;
                if (col_q == cols_q) begin
                    seq_last_xfer = 1'b1;
                end else begin
                    col_d = col_q + DIM_W'(1);
                    for (int i = 0; i < 5; i++)
                        sv_d[i] = sv_q[i] + 10'd1;
                    // Word 1 advances by 2 only when entering an even column.
                    sv_d[1] = sv_q[1] + (col_q[0] ? 10'd2 : 10'd0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cols_q <= '0;
            col_q  <= '0;
            widx_q <= 3'd0;
        end else begin
            cols_q <= cols_d;
            col_q  <= col_d;
            widx_q <= widx_d;
        end
    end

    for (genvar gi = 0; gi < 5; gi++) begin : g_sv
        always_ff @(posedge clk) begin
            if (!rst) sv_q[gi] <= 10'd0;
            else      sv_q[gi] <= sv_d[gi];
        end
    end
`else
    logic unused_seq_rdy;
    assign unused_seq_rdy = seq_datain_rdy;
    assign seq_valid      = 1'b0;
    assign seq_last_xfer  = 1'b0;
    assign seq_word       = '0;
`endif

    always_comb begin
        state_d    = state_q;
        rd_left_d  = rd_left_q;
        out_left_d = out_left_q;
        rd_addr_d  = rd_addr_q;
        rd_pend_d  = 1'b0;
        buf_d      = buf_q;
        buf_head_d = buf_head_q;
        buf_cnt_d  = buf_cnt_q;
        pix_rd_en  = 1'b0;
        rows_p1    = CW'(num_rows) + CW'(1);
        cols_p1    = CW'(num_cols) + CW'(1);
        map_size   = rows_p1 * cols_p1;
        pix_valid  = (state_q == S_PIX) && ((buf_cnt_q != 2'd0) || rd_pend_q);
        pix_word   = (buf_cnt_q != 2'd0) ? buf_q[buf_head_q] : pix_rd_data;
        pix_xfer   = pix_valid && pixel_datain_rdy;
        // A new read may only go out if a slot is guaranteed when it returns, even under stall.
        slot_free  = (buf_cnt_q == 2'd0) || ((buf_cnt_q == 2'd1) && !rd_pend_q);
        case (state_q)
            S_IDLE: if (start) begin
                rd_left_d  = map_size;
                out_left_d = map_size;
                rd_addr_d  = '0;
                state_d    = S_NEWMAP;
            end
`ifdef OCTO_LOADER_SEQ_GEN_EN
            S_NEWMAP: state_d = S_SEQ;
`else
            S_NEWMAP: state_d = S_GAP;
`endif
            S_SEQ: if (seq_last_xfer) state_d = S_GAP;
            S_GAP: begin
                pix_rd_en = 1'b1;
                state_d   = S_PIX;
            end
            S_PIX: begin
                pix_rd_en = (rd_left_q != '0) && slot_free;
                if (pix_xfer && out_left_q == CW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                rd_addr_d = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (pix_rd_en) begin
            rd_pend_d = 1'b1;
            rd_left_d = rd_left_q - CW'(1);
            if (rd_left_q != CW'(1))
                rd_addr_d = rd_addr_q + C_ADDR_WIDTH'(1);
        end
        if (pix_xfer)
            out_left_d = out_left_q - CW'(1);
        // Returning data bypasses the buffer when it is empty and accepted immediately.
        pop  = pix_xfer && (buf_cnt_q != 2'd0);
        push = rd_pend_q && !(pix_xfer && (buf_cnt_q == 2'd0));
        if (push)
            buf_d[buf_head_q ^ buf_cnt_q[0]] = pix_rd_data;
        if (pop)
            buf_head_d = ~buf_head_q;
        if (push && !pop)
            buf_cnt_d = buf_cnt_q + 2'd1;
        else if (pop && !push)
            buf_cnt_d = buf_cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rd_left_q  <= '0;
            out_left_q <= '0;
            rd_addr_q  <= '0;
            rd_pend_q  <= 1'b0;
            buf_head_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            rd_left_q  <= rd_left_d;
            out_left_q <= out_left_d;
            rd_addr_q  <= rd_addr_d;
            rd_pend_q  <= rd_pend_d;
            buf_head_q <= buf_head_d;
            buf_cnt_q  <= buf_cnt_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (!rst) buf_q[gi] <= '0;
            else      buf_q[gi] <= buf_d[gi];
        end
    end

    assign new_map          = (state_q == S_NEWMAP);
    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign seq_datain_tag   = seq_valid;
    assign pixel_datain_tag = pix_valid;
    assign datain_valid     = seq_valid || pix_valid;
    assign datain           = pix_valid ? DW'(pix_word) : (seq_valid ? DW'(seq_word) : '0);
    assign pix_rd_addr      = rd_addr_q;

endmodule

// File: tb/tb_cnn_layer_accel_octo_loader.sv
// Directed bench for cnn_layer_accel_octo_loader: table of loads plus reset/start corner sequences.
module tb_cnn_layer_accel_octo_loader;
    localparam int PW = 16, DW = 16, AW = 18, DIMW = 9;

    logic            clk = 1'b0;
    logic            rst, start, seq_datain_rdy, pixel_datain_rdy;
    logic [DIMW-1:0] num_rows, num_cols;
    logic            new_map, datain_valid, seq_datain_tag, pixel_datain_tag, pix_rd_en, busy, done;
    logic [DW-1:0]   datain;
    logic [AW-1:0]   pix_rd_addr;
    logic [PW-1:0]   pix_rd_data = '0;

    always #5 clk = ~clk;

    cnn_layer_accel_octo_loader dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .num_cols(num_cols),
        .new_map(new_map), .datain(datain), .datain_valid(datain_valid),
        .seq_datain_tag(seq_datain_tag), .seq_datain_rdy(seq_datain_rdy),
        .pixel_datain_tag(pixel_datain_tag), .pixel_datain_rdy(pixel_datain_rdy),
        .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
        .busy(busy), .done(done)
    );

    logic [PW-1:0] mem [0:255];
    int cur_total = 0;
    int addr_err  = 0;

    always @(posedge clk) begin
        if (pix_rd_en) begin
            pix_rd_data <= mem[pix_rd_addr[7:0]];
            if (int'(pix_rd_addr) >= cur_total) addr_err <= addr_err + 1;
        end
    end

    typedef struct {
        int rows; int cols; int mode; int exp_seq; int exp_pix; int glitch; int abort_at;
    } vec_t;
    vec_t vecs[8];

    int errors = 0;
    int checks = 0;
    logic [13:0] seq_got [0:63];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Closed-form sequence word for flat index idx (column idx/5, word idx%5).
    function automatic logic [13:0] seq_exp(input int idx);
        int k, w;
        logic [9:0] v;
        logic [13:0] r;
        k = idx / 5;
        w = idx % 5;
        case (w)
            0: begin v = 10'(k);             r = {(k > 0), 2'b01, (k % 2 == 0), v}; end
            1: begin v = 10'(2 + 2 * (k / 2)); r = {3'b000, (k % 2 == 1), v}; end
            2: begin v = 10'(512 + k);       r = {(k == 0), 3'b000, v}; end
            3: begin v = 10'(513 + k);       r = {4'b0000, v}; end
            default: begin v = 10'(514 + k); r = {4'b0100, v}; end
        endcase
        return r;
    endfunction

    task automatic run_load(input int id, input vec_t v);
        int seq_idx, pix_idx, last_seq, first_pix, last_pix, extra_nm, err0, exp_seq;
        logic prev_stall, prev_st, prev_pt;
        logic [DW-1:0] prev_data;
        bit finished;
`ifdef OCTO_LOADER_SEQ_GEN_EN
        exp_seq = v.exp_seq;
`else
        exp_seq = 0;
`endif
        cur_total = v.exp_pix;
        err0      = addr_err;
        @(negedge clk);
        num_rows = DIMW'(v.rows);
        num_cols = DIMW'(v.cols);
        start = 1'b1;
        seq_datain_rdy = 1'b1;
        pixel_datain_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("load%0d new_map/busy/valid at start", id), {new_map, busy, datain_valid}, 3'b110);
        seq_idx = 0; pix_idx = 0; last_seq = 0; first_pix = -1; last_pix = -1; extra_nm = 0;
        prev_stall = 1'b0; prev_st = 1'b0; prev_pt = 1'b0; prev_data = '0; finished = 0;
        for (int cyc = 1; cyc < 4000 && !finished; cyc++) begin
            @(negedge clk);
            if (new_map) extra_nm++;
            if (prev_stall)
                chk($sformatf("load%0d stall_hold", id), {datain, seq_datain_tag, pixel_datain_tag},
                    {prev_data, prev_st, prev_pt});
            chk($sformatf("load%0d tag_vs_valid", id),
                {seq_datain_tag | pixel_datain_tag, seq_datain_tag & pixel_datain_tag}, {datain_valid, 1'b0});
            if (datain_valid && seq_datain_tag) begin
                if (seq_idx == 0) chk($sformatf("load%0d seq_first_cycle", id), cyc, 1);
                chk($sformatf("load%0d seq_word[%0d]", id, seq_idx), datain, {2'b00, seq_exp(seq_idx)});
                if (seq_idx < 64) seq_got[seq_idx] = datain[13:0];
            end
            if (datain_valid && pixel_datain_tag) begin
                if (first_pix < 0) begin
                    first_pix = cyc;
                    chk($sformatf("load%0d gap_one_cycle", id), cyc, last_seq + 2);
                end
                if (pix_idx < 256)
                    chk($sformatf("load%0d pixel[%0d]", id, pix_idx), datain, mem[pix_idx]);
                if (v.abort_at >= 0 && pix_idx == v.abort_at) begin
                    rst = 1'b0;
                    @(negedge clk);
                    chk($sformatf("load%0d abort_outputs_zero", id),
                        {new_map, datain, datain_valid, seq_datain_tag, pixel_datain_tag,
                         pix_rd_en, pix_rd_addr, busy, done}, 64'd0);
                    rst = 1'b1;
                    $display("load %0d: rows=%0d cols=%0d reset at pixel %0d", id, v.rows, v.cols, pix_idx);
                    return;
                end
            end
            if (done) begin
                chk($sformatf("load%0d done_latency", id), cyc, last_pix + 1);
                chk($sformatf("load%0d busy_during_done", id), busy, 1'b1);
                @(negedge clk);
                chk($sformatf("load%0d done_single_pulse", id), {done, busy}, 2'b00);
                finished = 1;
            end else begin
                if (v.mode == 0) begin
                    seq_datain_rdy = 1'b1;
                    pixel_datain_rdy = 1'b1;
                end else begin
                    seq_datain_rdy = 1'($urandom_range(0, 1));
                    pixel_datain_rdy = 1'($urandom_range(0, 1));
                end
                if (v.glitch != 0 && cyc == 3) begin
                    start = 1'b1;
                    num_cols = DIMW'(2);
                end else begin
                    start = 1'b0;
                    num_cols = DIMW'(v.cols);
                end
                if (datain_valid && seq_datain_tag && seq_datain_rdy) begin
                    seq_idx++;
                    last_seq = cyc;
                end
                if (datain_valid && pixel_datain_tag && pixel_datain_rdy) begin
                    pix_idx++;
                    last_pix = cyc;
                end
                prev_stall = datain_valid && !(seq_datain_tag ? seq_datain_rdy : pixel_datain_rdy);
                prev_data  = datain;
                prev_st    = seq_datain_tag;
                prev_pt    = pixel_datain_tag;
            end
        end
        start = 1'b0;
        chk($sformatf("load%0d finished_in_budget", id), finished, 1'b1);
        chk($sformatf("load%0d seq_count", id), seq_idx, exp_seq);
        chk($sformatf("load%0d pix_count", id), pix_idx, v.exp_pix);
        chk($sformatf("load%0d single_new_map", id), extra_nm, 0);
        chk($sformatf("load%0d addr_range", id), addr_err - err0, 0);
        if (v.mode == 0 && exp_seq > 0)
            chk($sformatf("load%0d seq_back_to_back", id), last_seq, exp_seq);
        if (v.mode == 0)
            chk($sformatf("load%0d pix_back_to_back", id), last_pix - first_pix, v.exp_pix - 1);
        $display("load %0d: rows=%0d cols=%0d mode=%0d seq_words=%0d pixels=%0d", id, v.rows, v.cols,
                 v.mode, seq_idx, pix_idx);
    endtask

    initial begin
        //          rows cols mode seq  pix glitch abort
        vecs[0] = '{9,   9,   0,   50, 100, 0,     -1};
        vecs[1] = '{9,   9,   1,   50, 100, 0,     -1};
        vecs[2] = '{0,   0,   0,   5,  1,   0,     -1};
        vecs[3] = '{0,   0,   1,   5,  1,   0,     -1};
        vecs[4] = '{3,   6,   1,   35, 28,  0,     -1};
        vecs[5] = '{9,   9,   0,   50, 100, 1,     -1};
        vecs[6] = '{9,   9,   0,   50, 100, 0,     43};
        vecs[7] = '{9,   9,   0,   50, 100, 0,     -1};
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0135 + 16'h5A00);

        rst = 1'b0; start = 1'b0; num_rows = '0; num_cols = '0;
        seq_datain_rdy = 1'b0; pixel_datain_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", {new_map, datain, datain_valid, seq_datain_tag, pixel_datain_tag,
                                   pix_rd_en, pix_rd_addr, busy, done}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_load(i, vecs[i]);
`ifdef OCTO_LOADER_SEQ_GEN_EN
            if (i == 0) begin
                chk("word5",  seq_got[5],  {4'b1010, 10'd1});
                chk("word6",  seq_got[6],  {4'b0001, 10'd2});
                chk("word9",  seq_got[9],  {4'b0100, 10'd515});
                chk("word10", seq_got[10], {4'b1011, 10'd2});
                chk("word11", seq_got[11], {4'b0000, 10'd4});
            end
`endif
            repeat (2) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
